// File: rtl/clock_divider_bank.sv
// clock_divider_bank: bank of glitch-free programmable clock dividers with phase offset and tick
module clock_divider_bank #(
  parameter int CHANNELS    = 4,
  parameter int CNT_WIDTH   = 8,
  parameter int SEL_WIDTH   = 2,
  parameter int DEFAULT_DIV = 2
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 resync,
  input  logic                 cfg_wren,
  input  logic [SEL_WIDTH-1:0] cfg_channel,
  input  logic [CNT_WIDTH-1:0] cfg_div,
  input  logic [CNT_WIDTH-1:0] cfg_phase,
  output logic [CHANNELS-1:0]  clk_out,
  output logic [CHANNELS-1:0]  tick,
  output logic [CHANNELS-1:0]  cfg_pending
);
  localparam logic [CNT_WIDTH-1:0] ONE = 1;
  localparam logic [CNT_WIDTH-1:0] TWO = 2;
  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d, div_q, div_d, phase_q, phase_d;
    logic [CNT_WIDTH-1:0] pdiv_q, pdiv_d, pphase_q, pphase_d, cnt_n;
    logic pend_q, pend_d, clk_q, clk_d, tick_q, tick_d, hit, apply, en;
    // pending config lands at terminal count, immediately when disabled, or on resync
    always_comb begin
      hit      = cfg_wren && cfg_channel == SEL_WIDTH'(c);
      apply    = pend_q && (resync || div_q < TWO || cnt_q == div_q - ONE);
      div_d    = apply ? pdiv_q : div_q;
      phase_d  = apply ? pphase_q : phase_q;
      en       = div_d >= TWO;
      cnt_n    = (apply || cnt_q == div_q - ONE) ? '0 : cnt_q + ONE;
      cnt_d    = !en ? '0 : resync ? (phase_d < div_d ? phase_d : '0) : cnt_n;
      clk_d    = en && !resync && cnt_n < (div_d >> 1);
      tick_d   = en && !resync && cnt_n == '0;
      pend_d   = hit || (pend_q && !apply);
      pdiv_d   = hit ? cfg_div : pdiv_q;
      pphase_d = hit ? cfg_phase : pphase_q;
    end
    always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
        cnt_q    <= '0;
        div_q    <= CNT_WIDTH'(DEFAULT_DIV);
        phase_q  <= '0;
        pdiv_q   <= CNT_WIDTH'(DEFAULT_DIV);
        pphase_q <= '0;
        pend_q   <= 1'b0;
        clk_q    <= 1'b0;
        tick_q   <= 1'b0;
      end else begin
        cnt_q    <= cnt_d;
        div_q    <= div_d;
        phase_q  <= phase_d;
        pdiv_q   <= pdiv_d;
        pphase_q <= pphase_d;
        pend_q   <= pend_d;
        clk_q    <= clk_d;
        tick_q   <= tick_d;
      end
    end
    assign clk_out[c]     = clk_q;
    assign tick[c]        = tick_q;
    assign cfg_pending[c] = pend_q;
  end
endmodule

// File: tb/tb_clock_divider_bank.sv
// tb_clock_divider_bank: directed scenarios with a queued expectation per clock edge
module tb_clock_divider_bank;
  localparam int CH = 4, CW = 4, SW = 3;
  logic clock = 1'b0, reset = 1'b1, resync = 1'b0, cfg_wren = 1'b0;
  logic [SW-1:0] cfg_channel = '0;
  logic [CW-1:0] cfg_div = '0, cfg_phase = '0;
  logic [CH-1:0] clk_out, tick, cfg_pending;
  typedef struct {
    int e;
    logic [CH-1:0] c, t, p;
  } exp_t;
  exp_t sb[$];
  exp_t mx;
  int checks = 0, errors = 0, edge_n = 0;
  int ediv[CH], ek0[CH];
  bit edis[CH], epend[CH];

  clock_divider_bank #(.CHANNELS(CH), .CNT_WIDTH(CW), .SEL_WIDTH(SW), .DEFAULT_DIV(2)) dut (
    .clock(clock), .reset(reset), .resync(resync), .cfg_wren(cfg_wren),
    .cfg_channel(cfg_channel), .cfg_div(cfg_div), .cfg_phase(cfg_phase),
    .clk_out(clk_out), .tick(tick), .cfg_pending(cfg_pending)
  );

  always #5 clock = ~clock;

  // expected channel phase: edge e sits (e - ek0) mod div into a period that began at edge ek0
  task automatic step(input bit zero = 1'b0);
    exp_t x;
    int m;
    edge_n++;
    x.e = edge_n;
    for (int c = 0; c < CH; c++) begin
      m = ((edge_n - ek0[c]) % ediv[c] + ediv[c]) % ediv[c];
      x.c[c] = !zero && !edis[c] && m < ediv[c] / 2;
      x.t[c] = !zero && !edis[c] && m == 0;
      x.p[c] = epend[c];
    end
    sb.push_back(x);
    @(posedge clock);
    @(negedge clock);
    cfg_wren = 1'b0;
    resync = 1'b0;
  endtask

  task automatic wr(input int ch, input int dv, input int ph);
    cfg_wren = 1'b1;
    cfg_channel = SW'(ch);
    cfg_div = CW'(dv);
    cfg_phase = CW'(ph);
  endtask

  initial forever begin
    @(posedge clock);
    #1;
    if (sb.size() != 0) begin
      mx = sb.pop_front();
      checks++;
      if (clk_out !== mx.c || tick !== mx.t || cfg_pending !== mx.p) begin
        errors++;
        $display("FAIL edge%0d clk_out/tick/pend got %b/%b/%b want %b/%b/%b",
                 mx.e, clk_out, tick, cfg_pending, mx.c, mx.t, mx.p);
      end
    end
  end

  initial begin
    for (int c = 0; c < CH; c++) begin
      ediv[c] = 2; ek0[c] = 0; edis[c] = 0; epend[c] = 0;
    end
    repeat (3) @(negedge clock);
    reset = 1'b0;
    repeat (6) step();
    reset = 1'b1;
    #1;
    checks++;
    if ({clk_out, tick, cfg_pending} !== '0) begin
      errors++;
      $display("FAIL async_reset got %b/%b/%b want all zero", clk_out, tick, cfg_pending);
    end
    repeat (2) @(negedge clock);
    reset = 1'b0;
    edge_n = 0;
    repeat (6) step();
    wr(1, 4, 0); epend[1] = 1; step();
    epend[1] = 0; ediv[1] = 4; ek0[1] = 8; step();
    repeat (5) step();
    wr(1, 6, 0); epend[1] = 1; step();
    step();
    epend[1] = 0; ediv[1] = 6; ek0[1] = 16; step();
    repeat (6) step();
    wr(0, 4, 0); epend[0] = 1; step();
    wr(2, 4, 2); epend[0] = 0; ediv[0] = 4; ek0[0] = 24; epend[2] = 1; step();
    resync = 1'b1; epend[2] = 0; ediv[2] = 4; ek0[2] = 23;
    ek0[0] = 25; ek0[1] = 25; ek0[3] = 25; step(1'b1);
    repeat (90) step();
    wr(3, 1, 0); epend[3] = 1; step();
    epend[3] = 0; edis[3] = 1; step();
    repeat (2) step();
    wr(3, 5, 0); epend[3] = 1; step();
    epend[3] = 0; edis[3] = 0; ediv[3] = 5; ek0[3] = 121; step();
    repeat (14) step();
    wr(0, 3, 0); epend[0] = 1; step();
    wr(0, 8, 0); ediv[0] = 3; ek0[0] = 137; step();
    repeat (2) step();
    epend[0] = 0; ediv[0] = 8; ek0[0] = 140; step();
    wr(5, 3, 1); step();
    wr(2, 15, 0); epend[2] = 1; step();
    epend[2] = 0; ediv[2] = 15; ek0[2] = 143; step();
    repeat (47) step();
    @(negedge clock);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain got %0d left want 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/clock_divider_bank.md
# clock_divider_bank

Parametrised bank of independent clock dividers. It generalises the fixed half-rate and quarter-rate dividers that feed the regfile and processor clocks. Each of `CHANNELS` outputs divides `clock` by a runtime-programmable ratio, with a programmable phase offset and a one-cycle rising-edge `tick`. Ratio changes take effect only at a period boundary, so outputs never glitch. The block sits in the top level beside memory and regfile clocking and replaces per-ratio divider modules.

## Interface
- `CHANNELS`, default 4: number of divider channels (1..16).
- `CNT_WIDTH`, default 8: counter and ratio width; the maximum ratio is 2^CNT_WIDTH-1.
- `SEL_WIDTH`, default 2: width of the channel select; must satisfy 2^SEL_WIDTH >= CHANNELS.
- `DEFAULT_DIV`, default 2: ratio loaded into every channel at reset.

Ports:
- `clock`  in  1  sole clock. Every register is updated on its rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `resync`  in  1  synchronous realign of all channels to their phase offsets.
- `cfg_wren`  in  1  config write strobe, sampled each edge.
- `cfg_channel`  in  SEL_WIDTH  target channel of the write.
- `cfg_div`  in  CNT_WIDTH  new ratio. Values 0 and 1 disable the channel.
- `cfg_phase`  in  CNT_WIDTH  new phase offset, used at the next resync.
- `clk_out`  out  CHANNELS  divided clocks, one bit per channel, registered.
- `tick`  out  CHANNELS  one-cycle pulse, high in the cycle `clk_out[i]` goes high.
- `cfg_pending`  out  CHANNELS  high while a written config is not yet applied.

## Operation
- **Per-channel state:** `cnt`, `div`, `phase`, `pend_div`, `pend_phase`, `pend`.
- **Enabled channel (div >= 2), each edge:**
  - `cnt_n = (cnt == div-1) ? 0 : cnt+1`.
  - `clk_out <= (cnt_n < div>>1)`.
  - `tick <= (cnt_n == 0)`.
- **Duty cycle:** the output is high for floor(div/2) cycles per period. Odd ratios are therefore low-biased; for example div=3 gives 1 cycle high and 2 low.
- **Disabled channel (div < 2):** `cnt` is held at 0, and `clk_out` and `tick` are 0.
- **Config write:** on an edge with `cfg_wren` and `cfg_channel < CHANNELS`:
  - `pend_div <= cfg_div`, `pend_phase <= cfg_phase`, `pend <= 1`.
  - Writes to `cfg_channel >= CHANNELS` are ignored.
  - A write to a channel that already has a pending config overwrites it (last write wins).
- **Apply rule:**
  - Pending config is applied on the edge where `cnt == div-1` (terminal count).
  - If the channel is disabled, it is applied on the next edge.
  - On apply: `div <= pend_div`, `phase <= pend_phase`, `cnt <= 0`, `pend <= 0`.
  - The outputs on that edge are computed with the new `div`, with `cnt_n = 0`.
- **Write and apply on the same edge:** the new write wins, becomes pending, and `pend` stays 1.
- **resync (synchronous, all channels):**
  - Any pending config is applied first.
  - `cnt <= (phase < div) ? phase : 0`, using the post-apply `phase` and `div`.
  - `clk_out <= 0`, `tick <= 0`.
  - `resync` has priority over normal counting.
  - A `cfg_wren` on the same edge is captured as pending after the resync apply.
- **reset (asynchronous):** `cnt=0`, `div=DEFAULT_DIV`, `phase=0`, `pend=0`, `clk_out=0`, `tick=0`, `cfg_pending=0`.

## Timing
- **After reset deassertion with DEFAULT_DIV=2:**
  - Edge 1: `clk_out=0`, `cnt=1`.
  - Edge 2: `clk_out=1`, `tick=1`.
  - The output then toggles every edge, matching the existing half-rate divider.
- **With div=4:** `clk_out` rises every 4 edges, with 2 edges high and 2 low. This matches the existing quarter-rate divider.
- **Output register:** `clk_out` and `tick` are registered, with no combinational path from any input.
- **`cfg_pending` latency:**
  - Rises on the edge after the write strobe is sampled.
  - Falls on the apply edge.
  - Worst-case pending time is `div` edges.
- **Phase after resync:** a channel with phase `p` produces its first `tick` `div-p` edges after the resync edge, or `div` edges when p=0.
- **Alignment:** channels with equal `div` and `phase` stay edge-aligned indefinitely after a common resync.
- **Counter wrap:** at `cnt = div-1` the counter returns to 0. There is no overflow for div = 2^CNT_WIDTH-1.

## Test plan
- **Reset defaults:** assert `reset` mid-period -> all outputs 0 immediately, without waiting for a clock edge. After release, every channel ticks at edges 2, 4, 6.
- **Glitch-free ratio change:** ch1 div=4 running; write div=6 at cnt=1 -> `cfg_pending[1]` is high for 2 edges. The current period completes at 4. The next period is 6 cycles, 3 high and 3 low, with no runt pulse.
- **Phase and resync:** ch0 div=4 phase=0, ch2 div=4 phase=2; pulse `resync` -> ch0 ticks 4 edges later and ch2 ticks 2 edges later; the offset is held for more than 20 periods.
- **Disable and odd ratio:** write div=1 to ch3 -> `clk_out[3]` is 0 from the apply edge on. Then write div=5 -> applied the next edge, giving 2 high and 3 low.
- **Simultaneous events:** `cfg_wren` to ch0 (div=8) on the same edge as a ch0 apply -> the new value stays pending. A write to channel 5 with CHANNELS=4 -> no state change.
- **Wrap at maximum:** CNT_WIDTH=4, div=15 -> `tick` period is exactly 15 with 7 cycles high; the counter never exceeds 14.
